// File: rtl/hamming_enc_sched_pkg.sv
// Shared definitions for the Hamming encoder scheduler slice.
package hamming_enc_sched_pkg;

  localparam int unsigned PATTERN_WIDTH = 8;
  localparam int unsigned PARITY_WIDTH  = 4;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned REQ_ID_W = 3;

  typedef logic [PATTERN_WIDTH-1:0] pattern_t;
  typedef logic [PARITY_WIDTH-1:0]  parity_t;
  typedef logic [REQ_ID_W-1:0]      req_id_t;

endpackage

// File: rtl/hamming_enc_sched_rr_arbiter.sv
// Round-robin arbiter: first request at or above the pointer wins, with wrap.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (i_advance) begin
      ptr <= (o_grant_idx == IW'(N-1)) ? '0 : o_grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/hamming_enc_sched.sv
// Shares one non-stallable hamming_enc among NUM_REQ requesters; results are
// captured with the requester ID into a small output FIFO.
module hamming_enc_sched
  import hamming_enc_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = $clog2(NUM_REQ),
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  pattern_t [NUM_REQ-1:0] i_req_pattern,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic                  o_enc_en,
  output logic                  o_enc_valid,
  output pattern_t              o_enc_pattern,
  input  pattern_t              i_enc_pattern,
  input  parity_t               i_enc_parity,
  output logic                  o_valid,
  output pattern_t              o_pattern,
  output parity_t               o_parity,
  output logic [ID_W-1:0]       o_id,
  input  logic                  i_ready
);

  localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

  pattern_t        fifo_pat [OUT_DEPTH];
  parity_t         fifo_par [OUT_DEPTH];
  logic [ID_W-1:0] fifo_id  [OUT_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            inflight;
  logic [ID_W-1:0] inflight_id;

  logic            pop;
  logic            push;
  logic [CW:0]     occ;
  logic            can_issue;
  logic [NUM_REQ-1:0] req_elig;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            granted;

  assign o_valid = (count != '0);
  assign pop     = o_valid & i_ready;
  assign push    = inflight;

  // Reserve a slot for every result already owed (stored + in flight) so the
  // encoder, which cannot stall, never pushes into a full FIFO.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign can_issue = occ < (CW+1)'(OUT_DEPTH);
  assign req_elig  = i_req_valid & {NUM_REQ{can_issue & i_rst_n}};

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (req_elig),
    .i_advance   (granted),
    .o_grant     (grant),
    .o_grant_idx (grant_idx)
  );

  assign granted       = |grant;
  assign o_req_ready   = grant;
  assign o_enc_en      = granted;
  assign o_enc_valid   = granted;
  assign o_enc_pattern = granted ? i_req_pattern[grant_idx] : '0;

  assign o_pattern = fifo_pat[rd_ptr];
  assign o_parity  = fifo_par[rd_ptr];
  assign o_id      = fifo_id[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight    <= 1'b0;
      inflight_id <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        fifo_pat[i] <= '0;
        fifo_par[i] <= '0;
        fifo_id[i]  <= '0;
      end
    end else begin
      inflight <= granted;
      if (granted) inflight_id <= grant_idx;
      if (push) begin
        fifo_pat[wr_ptr] <= i_enc_pattern;
        fifo_par[wr_ptr] <= i_enc_parity;
        fifo_id[wr_ptr]  <= inflight_id;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(push && !pop && count == CW'(OUT_DEPTH)));

endmodule

// File: tb/tb_hamming_enc_sched.sv
// Bench for hamming_enc_sched: vector table, directed corner cases and a
// randomized run against a queue-based reference model.
module tb_hamming_enc_sched;
  import hamming_enc_sched_pkg::*;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req_vld;
  pattern_t [3:0]  req_pat;
  logic [3:0]      req_rdy;
  logic            enc_en, enc_valid;
  pattern_t        enc_pattern;
  pattern_t        enc_pat_q;
  parity_t         enc_par_q;
  logic            o_valid;
  pattern_t        o_pattern;
  parity_t         o_parity;
  logic [1:0]      o_id;
  logic            rdy;

  int checks;
  int failures;

  hamming_enc_sched #(
    .NUM_REQ   (4),
    .OUT_DEPTH (2)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_vld),
    .i_req_pattern (req_pat),
    .o_req_ready   (req_rdy),
    .o_enc_en      (enc_en),
    .o_enc_valid   (enc_valid),
    .o_enc_pattern (enc_pattern),
    .i_enc_pattern (enc_pat_q),
    .i_enc_parity  (enc_par_q),
    .o_valid       (o_valid),
    .o_pattern     (o_pattern),
    .o_parity      (o_parity),
    .o_id          (o_id),
    .i_ready       (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hamming(12,8): data bits sit at the non-power-of-two positions 3..12;
  // parity bit k covers every position with bit k set.
  function automatic parity_t hparity(input pattern_t d);
    parity_t p = '0;
    int unsigned pos = 1;
    for (int unsigned b = 0; b < PATTERN_WIDTH; b++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      for (int unsigned k = 0; k < PARITY_WIDTH; k++)
        if (((pos >> k) & 1) != 0) p[k] = p[k] ^ d[b];
      pos++;
    end
    return p;
  endfunction

  // Encoder stand-in: one-cycle registered result, never reset.
  always_ff @(posedge clk) begin
    if (enc_en && enc_valid) begin
      enc_pat_q <= enc_pattern;
      enc_par_q <= hparity(enc_pattern);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    pattern_t pat;
    parity_t  par;
    req_id_t  id;
  } entry_t;

  entry_t      mq[$];
  bit          m_infl;
  entry_t      m_inf;
  int unsigned m_ptr;

  task automatic do_reset();
    rst_n   = 1'b0;
    req_vld = '0;
    req_pat = '0;
    rdy     = 1'b0;
    mq.delete();
    m_infl = 1'b0;
    m_ptr  = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock of the reference model; inputs must already be driven.
  task automatic model_cycle(output logic [3:0] g);
    bit          exp_ov, pop, can, got;
    int unsigned gi, r;
    exp_ov = (mq.size() > 0);
    pop    = exp_ov && rdy;
    can    = (mq.size() + int'(m_infl) - int'(pop)) < 2;
    g = '0; got = 0; gi = 0;
    if (can) begin
      for (int unsigned k = 0; k < 4; k++) begin
        r = (m_ptr + k) % 4;
        if (!got && req_vld[r]) begin got = 1; gi = r; g[r] = 1'b1; end
      end
    end
    #1;
    check("req_ready", req_rdy, g);
    check("enc_en", enc_en, got);
    check("enc_valid", enc_valid, got);
    check("enc_pattern", enc_pattern, got ? req_pat[gi] : 8'h00);
    check("o_valid", o_valid, exp_ov);
    if (exp_ov) begin
      check("o_pattern", o_pattern, mq[0].pat);
      check("o_parity", o_parity, mq[0].par);
      check("o_id", o_id, mq[0].id);
    end
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (m_infl) mq.push_back(m_inf);
    m_infl = got;
    if (got) begin
      m_inf.pat = req_pat[gi];
      m_inf.par = hparity(req_pat[gi]);
      m_inf.id  = req_id_t'(gi);
      m_ptr     = (gi + 1) % 4;
    end
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  vld;
    logic [31:0] pats;
    logic        rdy;
    logic [3:0]  g;
    logic        ov;
    logic [7:0]  pat;
    logic [1:0]  id;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(bit rs, logic [3:0] v, logic [31:0] p, logic r,
                              logic [3:0] g, logic ov, logic [7:0] pt, logic [1:0] id);
    row_t x;
    x.rst = rs; x.vld = v; x.pats = p; x.rdy = r;
    x.g = g; x.ov = ov; x.pat = pt; x.id = id;
    return x;
  endfunction

  initial begin
    logic [3:0]  g;
    logic [31:0] pats;
    logic [7:0]  exp_ep;
    checks = 0;
    failures = 0;
    rst_n = 1'b0; req_vld = '0; req_pat = '0; rdy = 1'b0;
    #2;
    check("rst_req_ready", req_rdy, 4'b0);
    check("rst_enc_en", enc_en, 1'b0);
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_pattern", o_pattern, 8'h00);
    check("rst_o_id", o_id, 2'd0);

    // single request on requester 1
    tbl.push_back(mk(1, 4'b0010, 32'h0000_0000, 1, 4'b0010, 0, 8'h00, 0));
    tbl.push_back(mk(0, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(0, 4'b0000, 32'h0000_0000, 1, 4'b0000, 1, 8'h00, 1));
    tbl.push_back(mk(0, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h00, 0));
    // round-robin fairness, all requesters valid
    tbl.push_back(mk(1, 4'b1111, 32'h4433_2211, 1, 4'b0001, 0, 8'h00, 0));
    tbl.push_back(mk(0, 4'b1111, 32'h4433_2211, 1, 4'b0010, 0, 8'h00, 0));
    tbl.push_back(mk(0, 4'b1111, 32'h4433_2211, 1, 4'b0100, 1, 8'h11, 0));
    tbl.push_back(mk(0, 4'b1111, 32'h4433_2211, 1, 4'b1000, 1, 8'h22, 1));
    tbl.push_back(mk(0, 4'b1111, 32'h4433_2211, 1, 4'b0001, 1, 8'h33, 2));
    tbl.push_back(mk(0, 4'b1111, 32'h4433_2211, 1, 4'b0010, 1, 8'h44, 3));
    tbl.push_back(mk(0, 4'b0000, 32'h4433_2211, 1, 4'b0000, 1, 8'h11, 0));
    tbl.push_back(mk(0, 4'b0000, 32'h4433_2211, 1, 4'b0000, 1, 8'h22, 1));
    tbl.push_back(mk(0, 4'b0000, 32'h4433_2211, 1, 4'b0000, 0, 8'h00, 0));
    // backpressure, fill to full, then pop+grant in the same cycle
    tbl.push_back(mk(1, 4'b0101, 32'h003C_77A5, 0, 4'b0001, 0, 8'h00, 0));
    tbl.push_back(mk(0, 4'b0100, 32'h003C_77A5, 0, 4'b0100, 0, 8'h00, 0));
    tbl.push_back(mk(0, 4'b0010, 32'h003C_77A5, 0, 4'b0000, 1, 8'hA5, 0));
    tbl.push_back(mk(0, 4'b0010, 32'h003C_77A5, 0, 4'b0000, 1, 8'hA5, 0));
    tbl.push_back(mk(0, 4'b0010, 32'h003C_77A5, 1, 4'b0010, 1, 8'hA5, 0));
    tbl.push_back(mk(0, 4'b0000, 32'h003C_77A5, 1, 4'b0000, 1, 8'h3C, 2));
    tbl.push_back(mk(0, 4'b0000, 32'h003C_77A5, 1, 4'b0000, 1, 8'h77, 1));
    tbl.push_back(mk(0, 4'b0000, 32'h003C_77A5, 1, 4'b0000, 0, 8'h00, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      pats    = tbl[i].pats;
      req_vld = tbl[i].vld;
      req_pat = pats;
      rdy     = tbl[i].rdy;
      exp_ep  = 8'h00;
      for (int unsigned k = 0; k < 4; k++)
        if (tbl[i].g[k]) exp_ep = pats[k*8 +: 8];
      #1;
      check("tbl_req_ready", req_rdy, tbl[i].g);
      check("tbl_enc_en", enc_en, |tbl[i].g);
      check("tbl_enc_pattern", enc_pattern, exp_ep);
      check("tbl_o_valid", o_valid, tbl[i].ov);
      if (tbl[i].ov) begin
        check("tbl_o_pattern", o_pattern, tbl[i].pat);
        check("tbl_o_parity", o_parity, hparity(tbl[i].pat));
        check("tbl_o_id", o_id, tbl[i].id);
      end
      @(posedge clk);
      #1;
    end

    // reset with one stored result and one encode in flight
    do_reset();
    req_vld = 4'b0001; req_pat[0] = 8'h5A;
    model_cycle(g);
    req_vld = 4'b0010; req_pat[1] = 8'hC3;
    model_cycle(g);
    req_vld = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", req_rdy, 4'b0);
    check("mid_rst_enc_en", enc_en, 1'b0);
    check("mid_rst_enc_valid", enc_valid, 1'b0);
    check("mid_rst_enc_pattern", enc_pattern, 8'h00);
    check("mid_rst_o_valid", o_valid, 1'b0);
    check("mid_rst_o_pattern", o_pattern, 8'h00);
    check("mid_rst_o_parity", o_parity, 4'h0);
    check("mid_rst_o_id", o_id, 2'd0);
    do_reset();
    req_vld = 4'b1000; req_pat[3] = 8'hE7; rdy = 1'b1;
    #1;
    check("post_rst_grant3", req_rdy, 4'b1000);
    model_cycle(g);
    req_vld = '0;
    repeat (3) model_cycle(g);

    // encoder result register stays loaded; nothing may re-emerge
    for (int i = 0; i < 10; i++) begin
      #1;
      check("idle_o_valid", o_valid, 1'b0);
      check("idle_enc_en", enc_en, 1'b0);
      @(posedge clk);
      #1;
    end

    // randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        if (!req_vld[r] && $urandom_range(99) < 40) begin
          req_vld[r] = 1'b1;
          req_pat[r] = pattern_t'($urandom);
        end else if (req_vld[r] && $urandom_range(99) < 8) begin
          req_vld[r] = 1'b0;
        end
      end
      rdy = ($urandom_range(99) < 70);
      model_cycle(g);
      req_vld = req_vld & ~g;
    end
    req_vld = '0;
    rdy = 1'b1;
    repeat (4) model_cycle(g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_enc_sched.md
Name: hamming_enc_sched

Overview:
- Shares one hamming_enc datapath among NUM_REQ requesters using round-robin arbitration.
- Drives the encoder's enable, valid and pattern inputs, and tracks the single in-flight encode.
- Captures each encoded pattern and parity, with the requester ID, into a small output FIFO.
- The encoder cannot stall, so the scheduler only issues when an output slot is guaranteed. Placement: between the requester ports and the downstream ECC consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), requester ID width.
- OUT_DEPTH, 2, output FIFO entries (power of 2, at least 2).

Ports:
- i_clk  in  1  single clock; all logic on posedge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_req_valid  in  NUM_REQ  per-requester request.
- i_req_pattern  in  NUM_REQ x pattern_t  per-requester data.
- o_req_ready  out  NUM_REQ  one-hot grant; transfer happens when valid and ready are both high.
- o_enc_en  out  1  to encoder i_en.
- o_enc_valid  out  1  to encoder i_valid.
- o_enc_pattern  out  pattern_t  to encoder i_pattern.
- i_enc_pattern  in  pattern_t  from encoder o_pattern.
- i_enc_parity  in  parity_t  from encoder o_parity.
- o_valid  out  1  output FIFO not empty.
- o_pattern  out  pattern_t  head-entry pattern.
- o_parity  out  parity_t  head-entry parity.
- o_id  out  ID_W  head-entry requester index.
- i_ready  in  1  downstream accept.

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - o_req_ready=0, o_enc_en=0, o_enc_valid=0, o_enc_pattern=0, o_valid=0, o_pattern=0, o_parity=0, o_id=0.
  - Round-robin pointer=0, FIFO empty, inflight=0.
  - Reset mid-operation discards stored and in-flight results. The stale encoder register is ignored because inflight=0.
- pop = o_valid & i_ready.
- can_issue = (count + inflight - pop) < OUT_DEPTH. count is the FIFO occupancy.
- Arbitration (combinational, same cycle):
  - If can_issue, grant the first valid requester searching from the pointer upward, with wrap-around.
  - o_req_ready is one-hot on the granted requester; all zero if there is no grant or !can_issue.
  - On a grant, the pointer becomes (granted index + 1) mod NUM_REQ at the next edge. Otherwise the pointer holds.
- Issue, in grant cycle C:
  - o_enc_en=o_enc_valid=1 and o_enc_pattern equals the granted pattern.
  - With no grant, o_enc_en=o_enc_valid=0 and o_enc_pattern=0.
- In-flight tracking:
  - At the end of C, inflight<=1 and inflight_id<=granted index. Otherwise inflight<=0.
  - The encoder's o_valid is NOT used; it is sticky.
- Capture, in cycle C+1 with inflight=1:
  - Push {i_enc_pattern, i_enc_parity, inflight_id} into the FIFO at the end of C+1.
- Latency: request handshake in cycle C gives o_valid no earlier than C+2.
- Throughput: 1 per cycle sustained when i_ready stays high.
- FIFO behaviour:
  - Push and pop in the same cycle are legal, including when full; count is unchanged.
  - The accounting guarantees a push never hits a full FIFO. An assertion flags overflow.
  - Output fields are defined only while o_valid=1.
  - o_pattern, o_parity and o_id stay stable while o_valid & !i_ready.
- Requesters must hold i_req_pattern stable while valid and not ready.
- Dropping i_req_valid before grant is legal (no transfer).
- Wrap-around: the pointer wraps from NUM_REQ-1 to 0. FIFO read and write pointers wrap modulo OUT_DEPTH.

Decomposition:
- Shared definitions: pattern_t and parity_t (PATTERN_WIDTH, PARITY_WIDTH) stay in the existing shared definitions. Add req_id_t there.
- One sub-module, rr_arbiter (parameter N):
  - Inputs: request vector, advance strobe.
  - Outputs: one-hot grant, grant index.
  - Owns the pointer register.
- The FIFO is inline in hamming_enc_sched.

Test Plan:
- Single request, with PATTERN_WIDTH=8 and a zero-pattern request on requester 1 in cycle 0: o_req_ready=4'b0010 in cycle 0, o_valid=1 in cycle 2 with o_pattern=8'h00, o_parity=0, o_id=1.
- Round-robin fairness: all 4 requesters valid continuously with i_ready=1 give grants in order 0,1,2,3,0,1; one grant per cycle; o_id sequence matches the grant order two cycles later.
- Backpressure: i_ready=0 with requesters 0 and 2 valid (patterns 8'hA5, 8'h3C) gives exactly 2 grants, then o_req_ready=0 and count=2. Raising i_ready drains A5 then 3C with parity matching the reference model, and grants resume the same cycle as the first pop.
- Full with simultaneous pop and push: FIFO full and i_ready=1 in one cycle allows a grant that cycle, with no overflow assertion and no lost data.
- Reset mid-operation: assert i_rst_n=0 with inflight=1 and count=1; all outputs go 0 immediately. After release, the first request on requester 3 gets grant 3 (pointer=0 and only 3 is valid), and no stale result appears on the output.
- Sticky encoder valid: after one encode, 10 idle cycles give o_valid=0 throughout and o_enc_en=0 throughout.
